// File: rtl/change_dispenser.sv
// Newspaper vending back end: turns release/change strobes into one-at-a-time
// paper/coin eject requests, tracking coin inventory and short-change events.
module change_dispenser #(
  parameter int NICKEL_INIT = 8,
  parameter int DIME_INIT   = 8,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             R,
  input  logic             N1,
  input  logic             D1,
  input  logic             D2,
  input  logic             ack,
  input  logic             refill,
  output logic             paper_req,
  output logic             nickel_req,
  output logic             dime_req,
  output logic             busy,
  output logic             lost,
  output logic             short_change,
  output logic [CNT_W-1:0] nickel_cnt,
  output logic [CNT_W-1:0] dime_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    NEXT   = 3'd1,
    PAPER  = 3'd2,
    DIME   = 3'd3,
    NICKEL = 3'd4,
    GAP    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] NICKEL_LOAD = CNT_W'(NICKEL_INIT);
  localparam logic [CNT_W-1:0] DIME_LOAD   = CNT_W'(DIME_INIT);

  state_t           state_r, state_s;
  logic             pend_paper_r, pend_paper_s;
  logic [2:0]       pend_nickel_r, pend_nickel_s;
  logic [1:0]       pend_dime_r, pend_dime_s;
  logic [CNT_W-1:0] nickel_cnt_r, nickel_cnt_s;
  logic [CNT_W-1:0] dime_cnt_r, dime_cnt_s;
  logic             short_r, short_s;
  logic             lost_r, lost_s;
  logic             busy_r, busy_s;
  logic             paper_req_r, nickel_req_r, dime_req_r;
  logic             strobe_any_s;

  assign strobe_any_s = R | N1 | D1 | D2;

  // Next-state, pending-work and inventory decisions
  always_comb begin
    state_s       = state_r;
    pend_paper_s  = pend_paper_r;
    pend_nickel_s = pend_nickel_r;
    pend_dime_s   = pend_dime_r;
    nickel_cnt_s  = nickel_cnt_r;
    dime_cnt_s    = dime_cnt_r;
    short_s       = short_r;
    case (state_r)
      IDLE: begin
        if (refill) begin
          nickel_cnt_s = NICKEL_LOAD;
          dime_cnt_s   = DIME_LOAD;
        end else begin
          nickel_cnt_s = nickel_cnt_r;
          dime_cnt_s   = dime_cnt_r;
        end
        if (strobe_any_s) begin
          pend_paper_s  = R;
          pend_nickel_s = {2'b00, N1};
          pend_dime_s   = {1'b0, D1} + {1'b0, D2};
          state_s       = NEXT;
        end else begin
          state_s = IDLE;
        end
      end
      NEXT: begin
        if (pend_paper_r) begin
          state_s = PAPER;
        end else if (pend_dime_r != 2'd0) begin
          if (dime_cnt_r != {CNT_W{1'b0}}) begin
            state_s = DIME;
          end else if (nickel_cnt_r >= CNT_W'(2)) begin
            // No dimes left: pay the dime as two nickels instead
            pend_dime_s   = pend_dime_r - 2'd1;
            pend_nickel_s = pend_nickel_r + 3'd2;
          end else begin
            pend_dime_s = pend_dime_r - 2'd1;
            short_s     = 1'b1;
          end
        end else if (pend_nickel_r != 3'd0) begin
          if (nickel_cnt_r != {CNT_W{1'b0}}) begin
            state_s = NICKEL;
          end else begin
            pend_nickel_s = 3'd0;
            short_s       = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      PAPER: begin
        if (ack) begin
          pend_paper_s = 1'b0;
          state_s      = GAP;
        end else begin
          state_s = PAPER;
        end
      end
      DIME: begin
        if (ack) begin
          pend_dime_s = pend_dime_r - 2'd1;
          if (dime_cnt_r != {CNT_W{1'b0}}) begin
            dime_cnt_s = dime_cnt_r - CNT_W'(1);
          end else begin
            dime_cnt_s = dime_cnt_r;
          end
          state_s = GAP;
        end else begin
          state_s = DIME;
        end
      end
      NICKEL: begin
        if (ack) begin
          pend_nickel_s = pend_nickel_r - 3'd1;
          if (nickel_cnt_r != {CNT_W{1'b0}}) begin
            nickel_cnt_s = nickel_cnt_r - CNT_W'(1);
          end else begin
            nickel_cnt_s = nickel_cnt_r;
          end
          state_s = GAP;
        end else begin
          state_s = NICKEL;
        end
      end
      GAP: begin
        state_s = NEXT;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    lost_s = (state_r != IDLE) && strobe_any_s;
  end

  // State, pending work, inventory and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      pend_paper_r  <= 1'b0;
      pend_nickel_r <= 3'd0;
      pend_dime_r   <= 2'd0;
      nickel_cnt_r  <= NICKEL_LOAD;
      dime_cnt_r    <= DIME_LOAD;
      short_r       <= 1'b0;
      lost_r        <= 1'b0;
      busy_r        <= 1'b0;
      paper_req_r   <= 1'b0;
      nickel_req_r  <= 1'b0;
      dime_req_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      pend_paper_r  <= pend_paper_s;
      pend_nickel_r <= pend_nickel_s;
      pend_dime_r   <= pend_dime_s;
      nickel_cnt_r  <= nickel_cnt_s;
      dime_cnt_r    <= dime_cnt_s;
      short_r       <= short_s;
      lost_r        <= lost_s;
      busy_r        <= busy_s;
      paper_req_r   <= (state_s == PAPER);
      nickel_req_r  <= (state_s == NICKEL);
      dime_req_r    <= (state_s == DIME);
    end
  end

  assign paper_req    = paper_req_r;
  assign nickel_req   = nickel_req_r;
  assign dime_req     = dime_req_r;
  assign busy         = busy_r;
  assign lost         = lost_r;
  assign short_change = short_r;
  assign nickel_cnt   = nickel_cnt_r;
  assign dime_cnt     = dime_cnt_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser: eject ordering, dime
// substitution, short change, dropped strobes, refill and async reset.
module tb_change_dispenser;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       R = 1'b0, N1 = 1'b0, D1 = 1'b0, D2 = 1'b0;
  logic       ack = 1'b0, refill = 1'b0;
  logic       paper_req, nickel_req, dime_req, busy, lost, short_change;
  logic [4:0] nickel_cnt, dime_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] seq;

  change_dispenser #(.NICKEL_INIT(8), .DIME_INIT(8), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .R(R), .N1(N1), .D1(D1), .D2(D2),
    .ack(ack), .refill(refill), .paper_req(paper_req), .nickel_req(nickel_req),
    .dime_req(dime_req), .busy(busy), .lost(lost), .short_change(short_change),
    .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Answers each request with ack 3 cycles later; records eject order as hex digits
  // (1 paper, 2 dime, 3 nickel) until busy falls.
  task automatic service(output logic [15:0] s);
    int   cyc = 0;
    logic multi = 1'b0;
    logic drop_bad = 1'b0;
    s = 16'h0;
    while (busy === 1'b1 && cyc < 200) begin
      if ((32'(paper_req) + 32'(dime_req) + 32'(nickel_req)) > 32'd1) multi = 1'b1;
      if (paper_req || dime_req || nickel_req) begin
        s = {s[11:0], (paper_req ? 4'h1 : (dime_req ? 4'h2 : 4'h3))};
        repeat (3) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        if (paper_req || dime_req || nickel_req) drop_bad = 1'b1;
        cyc += 4;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("service_timeout", 16'(cyc < 200), 16'h1);
    check("one_hot_req", 16'(multi), 16'h0);
    check("req_drop_on_ack", 16'(drop_bad), 16'h0);
  endtask

  task automatic txn(input logic r, input logic n1, input logic d1, input logic d2,
                     input logic [15:0] exp_seq, input string tag);
    R = r; N1 = n1; D1 = d1; D2 = d2;
    @(negedge clk);
    R = 1'b0; N1 = 1'b0; D1 = 1'b0; D2 = 1'b0;
    service(seq);
    check(tag, seq, exp_seq);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_reqs", 16'({paper_req, dime_req, nickel_req}), 16'h0);
    check("rst_flags", 16'({busy, lost, short_change}), 16'h0);
    check("rst_nickel", 16'(nickel_cnt), 16'd8);
    check("rst_dime", 16'(dime_cnt), 16'd8);

    // R+D1 with explicit latency checks
    R = 1'b1; D1 = 1'b1;
    @(negedge clk);
    R = 1'b0; D1 = 1'b0;
    check("cap_busy", 16'(busy), 16'h1);
    check("cap_no_req_yet", 16'(paper_req), 16'h0);
    @(negedge clk);
    check("first_req", 16'(paper_req), 16'h1);
    service(seq);
    check("t1_seq", seq, 16'h0012);
    check("t1_dime", 16'(dime_cnt), 16'd7);
    check("t1_nickel", 16'(nickel_cnt), 16'd8);
    check("t1_busy", 16'(busy), 16'h0);
    check("t1_short", 16'(short_change), 16'h0);

    // Refill in IDLE, then all four strobes
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    check("refill_dime", 16'(dime_cnt), 16'd8);
    txn(1'b1, 1'b1, 1'b1, 1'b1, 16'h1223, "t2_seq");
    check("t2_dime", 16'(dime_cnt), 16'd6);
    check("t2_nickel", 16'(nickel_cnt), 16'd7);

    // Strobe and refill during an active paper_req
    R = 1'b1;
    @(negedge clk);
    R = 1'b0;
    @(negedge clk);
    check("t5_paper_req", 16'(paper_req), 16'h1);
    N1 = 1'b1; refill = 1'b1;
    @(negedge clk);
    N1 = 1'b0; refill = 1'b0;
    check("t5_lost_pulse", 16'(lost), 16'h1);
    @(negedge clk);
    check("t5_lost_clear", 16'(lost), 16'h0);
    service(seq);
    check("t5_seq", seq, 16'h0001);
    check("t5_counts", 16'({nickel_cnt, 3'b0, dime_cnt}), 16'({5'd7, 3'b0, 5'd6}));

    // Async reset while dime_req is high
    D1 = 1'b1;
    @(negedge clk);
    D1 = 1'b0;
    @(negedge clk);
    check("t6_dime_req", 16'(dime_req), 16'h1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_drop", 16'(dime_req), 16'h0);
    check("t6_busy", 16'(busy), 16'h0);
    check("t6_counts", 16'({nickel_cnt, 3'b0, dime_cnt}), 16'({5'd8, 3'b0, 5'd8}));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, "t6_after_reset");

    // Drain dimes, then substitute two nickels for a dime
    for (int i = 0; i < 4; i++) txn(1'b0, 1'b0, 1'b1, 1'b1, 16'h0022, "drain_dime");
    check("t3_dime_empty", 16'(dime_cnt), 16'd0);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 16'h0033, "t3_subst_seq");
    check("t3_nickel", 16'(nickel_cnt), 16'd6);
    check("t3_short", 16'(short_change), 16'h0);

    // One nickel left, D1+N1 -> short change
    for (int i = 0; i < 5; i++) txn(1'b0, 1'b1, 1'b0, 1'b0, 16'h0003, "drain_nickel");
    check("t4_nickel_one", 16'(nickel_cnt), 16'd1);
    txn(1'b0, 1'b1, 1'b1, 1'b0, 16'h0003, "t4_seq");
    check("t4_short", 16'(short_change), 16'h1);
    check("t4_nickel", 16'(nickel_cnt), 16'd0);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, "t4_paper");
    check("t4_short_sticky", 16'(short_change), 16'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t4_short_reset", 16'(short_change), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
